mem_arbiter: RTL and testbench

//  Shares one main-memory port between I-cache refills (fetch) and D-cache refill/writeback (memory stage).

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_sel.sv | 57 +++++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory-port arbiter.
package mem_arb_pkg;

  // Transaction sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Which requester owns the transaction in flight.
  typedef enum logic [1:0] {
    NONE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } owner_e;

  // Number of byte-offset bits inside one cache line.
  function automatic int line_off_bits(input int line_w);
    return $clog2(line_w / 8);
  endfunction

endpackage

// File: rtl/mem_arb_sel.sv
// Grant selection: D-side priority with a bounded streak so a pending
// I-side request is forced through after MAX_D_STREAK consecutive D grants.
module mem_arb_sel
  import mem_arb_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   ic_req_i,
  input  logic   dc_req_i,
  input  logic   grant_i,
  output owner_e winner_o
);

  localparam int                 StreakW   = $clog2(MAX_D_STREAK + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_D_STREAK);

  logic [StreakW-1:0] d_streak_q;
  logic [StreakW-1:0] d_streak_d;

  // Winner: D unless I is pending and D has used up its streak.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    winner_o = NONE;
    if (dc_req_i && !(ic_req_i && (d_streak_q == StreakMax))) begin
      winner_o = OWN_D;
    end else if (ic_req_i) begin
      winner_o = OWN_I;
    end
  end

  // Streak update on a grant: count D wins that starved a waiting I, otherwise clear.
  always_comb begin
    d_streak_d = d_streak_q;
    if (grant_i) begin
      if ((winner_o == OWN_D) && ic_req_i) begin
        if (d_streak_q != StreakMax) begin
          d_streak_d = d_streak_q + 1'b1;
        end
      end else begin
        d_streak_d = '0;
      end
    end
  end

  // Streak register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      d_streak_q <= '0;
    end else begin
      d_streak_q <= d_streak_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between I-cache refills and D-cache
// refill/writeback. One line transaction at a time:
// IDLE -> I_BUSY | D_BUSY -> RESP -> IDLE.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LINE_W       = 128,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [31:0]       ic_addr,
  input  logic              ic_cancel,
  output logic              ic_ack,
  output logic [LINE_W-1:0] ic_rdata,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [31:0]       dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_ack,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int          OffW     = line_off_bits(LINE_W);
  localparam logic [31:0] AddrMask = ~((32'd1 << OffW) - 32'd1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              cancel_q, cancel_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;

  owner_e winner;
  logic   grant;

  // Requests are only sampled in IDLE.
  assign grant = (state_q == IDLE) && (winner != NONE);

  mem_arb_sel #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_sel (
    .clk     (clk),
    .reset   (reset),
    .ic_req_i(ic_req),
    .dc_req_i(dc_req),
    .grant_i (grant),
    .winner_o(winner)
  );

  // Next state: capture the granted side's request, wait for memory, respond for one cycle.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cancel_d    = cancel_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (winner == OWN_I) begin
          state_d     = I_BUSY;
          owner_d     = OWN_I;
          mem_we_d    = 1'b0;
          mem_addr_d  = ic_addr & AddrMask;
          mem_wdata_d = '0;
          // A redirect in the grant cycle already kills the response.
          cancel_d    = ic_cancel;
        end else if (winner == OWN_D) begin
          state_d     = D_BUSY;
          owner_d     = OWN_D;
          mem_we_d    = dc_we;
          mem_addr_d  = dc_addr & AddrMask;
          mem_wdata_d = dc_wdata;
        end
      end
      I_BUSY: begin
        if (ic_cancel) begin
          cancel_d = 1'b1;
        end
        if (mem_ready) begin
          rdata_d = mem_rdata;
          state_d = RESP;
        end
      end
      D_BUSY: begin
        if (mem_ready) begin
          rdata_d = mem_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d  = IDLE;
        owner_d  = NONE;
        cancel_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, request and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= NONE;
      cancel_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      // NOTE: wide line registers are reset too because they drive outputs that must read zero after reset.
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cancel_q    <= cancel_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // mem_req decodes straight from state so an asynchronous reset drops it at once.
  assign mem_req   = (state_q == I_BUSY) || (state_q == D_BUSY);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);

  assign ic_ack   = (state_q == RESP) && (owner_q == OWN_I) && !cancel_q;
  assign dc_ack   = (state_q == RESP) && (owner_q == OWN_D);
  assign ic_rdata = rdata_q;
  assign dc_rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table of request patterns,
// per-side expected-ack queues, a cycle-stepped memory model and
// hand-written cancel / reset / stall / starvation sequences.
module tb_mem_arbiter;

  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              reset;
  logic              ic_req, ic_cancel, dc_req, dc_we, mem_ready;
  logic [31:0]       ic_addr, dc_addr;
  logic [LINE_W-1:0] dc_wdata, mem_rdata;
  logic              ic_ack, dc_ack, mem_req, mem_we, busy;
  logic [LINE_W-1:0] ic_rdata, dc_rdata, mem_wdata;
  logic [31:0]       mem_addr;

  mem_arbiter #(.LINE_W(LINE_W), .MAX_D_STREAK(4)) dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_cancel(ic_cancel),
    .ic_ack(ic_ack), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_ack(dc_ack), .dc_rdata(dc_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]       addr;
    logic              we;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
  } exp_t;

  typedef struct {
    logic              do_i;
    logic              do_d;
    logic              dc_we;
    logic [31:0]       ic_addr;
    logic [31:0]       dc_addr;
    logic [LINE_W-1:0] dc_wdata;
    int                wait_c;
    int                exp_order;  // base-4 digits, oldest ack first: 1=I, 2=D
  } vec_t;

  exp_t exp_i_q[$];
  exp_t exp_d_q[$];
  int   streak_log[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Memory model and monitor state.
  int                mem_wait = 0;
  int                wait_cnt = 0;
  int                ready_cyc = 0;
  int                rise_cyc = 0;
  int                first_rise_cyc = -1;
  int                mem_done_cnt = 0;
  int                ic_ack_cnt = 0;
  int                dc_ack_cnt = 0;
  int                order_code = 0;
  int                dc_reissue = 0;
  logic              prev_mem_req = 1'b0;
  logic              prev_ack = 1'b0;
  logic [31:0]       txn_addr = '0;
  logic              txn_we = 1'b0;
  logic [LINE_W-1:0] txn_wdata = '0;

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line content the memory returns for an aligned address.
  function automatic logic [LINE_W-1:0] line_of(input logic [31:0] a);
    return {a ^ 32'hA5A5_A5A5, ~a, a + 32'h0101_0101, a};
  endfunction

  task automatic req_i(input logic [31:0] a);
    exp_t e;
    ic_req  = 1'b1;
    ic_addr = a;
    e.addr  = a & ~32'hF;
    e.we    = 1'b0;
    e.wdata = '0;
    e.rdata = line_of(a & ~32'hF);
    exp_i_q.push_back(e);
  endtask

  task automatic req_d(input logic [31:0] a, input logic we, input logic [LINE_W-1:0] wd);
    exp_t e;
    dc_req   = 1'b1;
    dc_addr  = a;
    dc_we    = we;
    dc_wdata = wd;
    e.addr   = a & ~32'hF;
    e.we     = we;
    e.wdata  = wd;
    e.rdata  = line_of(a & ~32'hF);
    exp_d_q.push_back(e);
  endtask

  // One clock: sample outputs 1ns after the edge, score acks, drive the memory model.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;

    if (mem_req && !prev_mem_req) begin
      txn_addr  = mem_addr;
      txn_we    = mem_we;
      txn_wdata = mem_wdata;
      rise_cyc  = cyc;
      if (first_rise_cyc < 0) first_rise_cyc = cyc;
    end else if (mem_req) begin
      check("mem_hold_addr_we", {mem_addr, mem_we}, {txn_addr, txn_we});
      check("mem_hold_wdata", mem_wdata, txn_wdata);
      check("busy_while_wait", busy, 1);
    end

    if (prev_ack) check("busy_after_ack", busy, 0);

    if (ic_ack || dc_ack) begin
      check("ack_exclusive", ic_ack & dc_ack, 0);
      check("ack_one_cycle", prev_ack, 0);
      check("ack_latency", cyc, ready_cyc + 1);
      check("mem_req_in_resp", mem_req, 0);
      check("busy_in_resp", busy, 1);
    end

    if (ic_ack) begin
      ic_ack_cnt++;
      if (exp_i_q.size() == 0) begin
        check("ic_ack_unexpected", ic_ack, 0);
      end else begin
        e = exp_i_q.pop_front();
        check("ic_mem_addr", txn_addr, e.addr);
        check("ic_mem_we", txn_we, 0);
        check("ic_rdata", ic_rdata, e.rdata);
      end
      order_code = order_code * 4 + 1;
      streak_log.push_back(int'(dut.u_sel.d_streak_q));
      ic_req = 1'b0;
    end

    if (dc_ack) begin
      dc_ack_cnt++;
      if (exp_d_q.size() == 0) begin
        check("dc_ack_unexpected", dc_ack, 0);
      end else begin
        e = exp_d_q.pop_front();
        check("dc_mem_addr", txn_addr, e.addr);
        check("dc_mem_we", txn_we, e.we);
        if (e.we) check("dc_mem_wdata", txn_wdata, e.wdata);
        else      check("dc_rdata", dc_rdata, e.rdata);
      end
      order_code = order_code * 4 + 2;
      streak_log.push_back(int'(dut.u_sel.d_streak_q));
      if (dc_reissue > 0) begin
        dc_reissue--;
        req_d(dc_addr + 32'h100, 1'b0, {4{$urandom}});
      end else begin
        dc_req = 1'b0;
      end
    end
    prev_ack = ic_ack | dc_ack;

    if (mem_req) begin
      if (wait_cnt == mem_wait) begin
        mem_ready = 1'b1;
        mem_rdata = line_of(mem_addr);
        ready_cyc = cyc;
        mem_done_cnt++;
      end else begin
        mem_ready = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ready = 1'b0;
      mem_rdata = '0;
      wait_cnt  = 0;
    end
    prev_mem_req = mem_req;
  endtask

  // Step until no ack is outstanding and the arbiter is idle, bounded.
  task automatic drain(input string name, input int max_cyc);
    int n = 0;
    while ((exp_i_q.size() != 0 || exp_d_q.size() != 0 || busy) && n < max_cyc) begin
      step();
      n++;
    end
    check({name, "_pending_acks"}, exp_i_q.size() + exp_d_q.size(), 0);
    check({name, "_idle"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   drive_cyc;
    int   done0, ack0;

    vecs[0] = '{1, 0, 0, 32'h0000_1234, 32'h0, '0, 3, 1};
    vecs[1] = '{1, 1, 1, 32'h0000_2468, 32'h0000_0040, {4{32'hCAFE_F00D}}, 2, 2*4+1};
    vecs[2] = '{0, 1, 0, 32'h0, 32'hDEAD_BEEF, '0, 0, 2};
    vecs[3] = '{1, 1, 0, 32'hFFFF_FFFF, 32'h8000_0010, '0, 1, 2*4+1};
    vecs[4] = '{0, 1, 1, 32'h0, 32'h0000_007F, {32'h1, 32'h2, 32'h3, 32'h4}, 5, 2};

    reset = 1'b1;
    ic_req = 0; ic_cancel = 0; dc_req = 0; dc_we = 0; mem_ready = 0;
    ic_addr = '0; dc_addr = '0; dc_wdata = '0; mem_rdata = '0;
    #1;
    check("rst_ctrl", {ic_ack, dc_ack, mem_req, mem_we, busy}, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", ic_rdata | dc_rdata | mem_wdata, 0);
    step();
    step();
    reset = 1'b0;
    step();

    // Vector table: request patterns, grant order, grant latency.
    for (int v = 0; v < 5; v++) begin
      mem_wait       = vecs[v].wait_c;
      order_code     = 0;
      first_rise_cyc = -1;
      if (vecs[v].do_d) req_d(vecs[v].dc_addr, vecs[v].dc_we, vecs[v].dc_wdata);
      if (vecs[v].do_i) req_i(vecs[v].ic_addr);
      drive_cyc = cyc;
      drain($sformatf("vec%0d", v), 100);
      check($sformatf("vec%0d_grant_latency", v), first_rise_cyc, drive_cyc + 1);
      check($sformatf("vec%0d_order", v), order_code, vecs[v].exp_order);
      step();
    end

    // Cancel in the 2nd wait cycle of an I transaction.
    mem_wait = 4;
    done0 = mem_done_cnt;
    ack0  = ic_ack_cnt;
    ic_req = 1'b1; ic_addr = 32'h0000_3000;
    step();
    step();
    ic_cancel = 1'b1;
    ic_req    = 1'b0;
    step();
    ic_cancel = 1'b0;
    drain("cancel_wait", 50);
    check("cancel_mem_done", mem_done_cnt, done0 + 1);
    check("cancel_no_ic_ack", ic_ack_cnt, ack0);

    // Cancel in the grant cycle itself.
    mem_wait = 1;
    done0 = mem_done_cnt;
    ic_req = 1'b1; ic_addr = 32'h0000_3400; ic_cancel = 1'b1;
    step();
    ic_cancel = 1'b0;
    ic_req    = 1'b0;
    check("cancel_grant_taken", mem_req, 1);
    drain("cancel_grant", 50);
    check("cancel_grant_mem_done", mem_done_cnt, done0 + 1);
    check("cancel_grant_no_ic_ack", ic_ack_cnt, ack0);

    // ic_cancel during a D transaction has no effect.
    mem_wait = 2;
    req_d(32'h0000_0900, 1'b0, '0);
    step();
    ic_cancel = 1'b1;
    step();
    ic_cancel = 1'b0;
    drain("cancel_on_d", 50);

    // Memory stall of 20 cycles with requester inputs churning after grant.
    mem_wait = 20;
    req_i(32'h0000_2000);
    for (int n = 0; n < 24; n++) begin
      step();
      if (ic_req) ic_addr = $urandom;
    end
    drain("stall", 50);

    // Asynchronous reset while D_BUSY.
    mem_wait = 10;
    ack0 = dc_ack_cnt;
    req_d(32'h0000_0300, 1'b1, {4{32'h5555_AAAA}});
    step();
    step();
    check("pre_reset_busy", {mem_req, busy}, 2'b11);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_mem_req", mem_req, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_mem_we_addr", {mem_we, mem_addr}, 0);
    exp_d_q.delete();
    dc_req = 1'b0;
    step();
    step();
    reset = 1'b0;
    for (int n = 0; n < 5; n++) step();
    check("rst_no_dc_ack", dc_ack_cnt, ack0);
    mem_wait = 2;
    req_d(32'h0000_0310, 1'b0, '0);
    drain("post_reset", 50);

    // Starvation: D re-requests after every ack while I waits.
    mem_wait   = 1;
    order_code = 0;
    streak_log.delete();
    dc_reissue = 4;
    req_d(32'h0000_0500, 1'b0, '0);
    req_i(32'h0000_4000);
    drain("starve", 300);
    check("starve_order", order_code, ((((2*4+2)*4+2)*4+2)*4+1)*4+2);
    check("starve_log_len", streak_log.size(), 6);
    if (streak_log.size() == 6) begin
      check("starve_streak_d1", streak_log[0], 1);
      check("starve_streak_d2", streak_log[1], 2);
      check("starve_streak_d3", streak_log[2], 3);
      check("starve_streak_d4", streak_log[3], 4);
      check("starve_streak_after_i", streak_log[4], 0);
      check("starve_streak_d_alone", streak_log[5], 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
